// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes, ALUOp classes, funct codes, mul/div op and FSM encodings.
package alu_ctrl_pkg;
    localparam logic [3:0] C_AND  = 4'd0,  C_OR   = 4'd1,  C_ADD  = 4'd2,  C_SUB  = 4'd3;
    localparam logic [3:0] C_SLT  = 4'd4,  C_SLL  = 4'd5,  C_SLLV = 4'd6,  C_BEQ  = 4'd7;
    localparam logic [3:0] C_LUI  = 4'd8,  C_ORI  = 4'd9,  C_BNE  = 4'd10, C_DEF  = 4'd11;
    localparam logic [3:0] C_MD   = 4'd12, C_SRL  = 4'd13, C_SRA  = 4'd14, C_NOR  = 4'd15;
    localparam logic [2:0] OP_DEF = 3'd0, OP_R   = 3'd1, OP_ADD = 3'd2, OP_SLT = 3'd3;
    localparam logic [2:0] OP_BEQ = 3'd4, OP_LUI = 3'd5, OP_ORI = 3'd6, OP_BNE = 3'd7;
    localparam logic [5:0] F_SLL  = 6'd0,  F_SRL   = 6'd2,  F_SRA = 6'd3,  F_SLLV = 6'd4;
    localparam logic [5:0] F_MULT = 6'd24, F_MULTU = 6'd25, F_DIV = 6'd26, F_DIVU = 6'd27;
    localparam logic [5:0] F_ADD  = 6'd32, F_SUB   = 6'd34, F_AND = 6'd36, F_OR   = 6'd37;
    localparam logic [5:0] F_NOR  = 6'd39, F_SLT   = 6'd42;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;
    typedef enum logic [1:0] {S_IDLE, S_MD_RUN, S_MD_DONE} state_e;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational (ALUOp, funct) -> ALU code, mul/div flag and op.
// ALU_CTRL_ERR_EN: illegal R-type funct decodes to DEFAULT and raises illegal_o.
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int FUNCT_W = 6,
    parameter int CTRL_W  = 4
) (
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic [CTRL_W-1:0]  code_o,
    output logic               is_md_o,
    output logic [1:0]         md_op_o
`ifdef ALU_CTRL_ERR_EN
    ,
    output logic               illegal_o
`endif
);
    always_comb begin
        code_o  = C_DEF;
        is_md_o = 1'b0;
        md_op_o = funct_i[1:0];
`ifdef ALU_CTRL_ERR_EN
        illegal_o = 1'b0;
`endif
        case (aluop_i)
            OP_R: case (funct_i)
                F_ADD:  code_o = C_ADD;
                F_SUB:  code_o = C_SUB;
                F_AND:  code_o = C_AND;
                F_OR:   code_o = C_OR;
                F_NOR:  code_o = C_NOR;
                F_SLT:  code_o = C_SLT;
                F_SLL:  code_o = C_SLL;
                F_SRL:  code_o = C_SRL;
                F_SRA:  code_o = C_SRA;
                F_SLLV: code_o = C_SLLV;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    code_o  = C_MD;
                    is_md_o = 1'b1;
                end
                default: begin
`ifdef ALU_CTRL_ERR_EN
                    code_o    = C_DEF;
                    illegal_o = 1'b1;
`else
                    code_o = C_SLLV;
`endif
                end
            endcase
            OP_ADD:  code_o = C_ADD;
            OP_SLT:  code_o = C_SLT;
            OP_BEQ:  code_o = C_BEQ;
            OP_LUI:  code_o = C_LUI;
            OP_ORI:  code_o = C_ORI;
            OP_BNE:  code_o = C_BNE;
            default: code_o = C_DEF;
        endcase
    end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with valid/ready and a mul/div step sequencer.
// ALU_CTRL_ERR_EN adds err_o, pulsed with valid_o for an illegal R-type funct.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W   = 3,
    parameter int FUNCT_W   = 6,
    parameter int CTRL_W    = 4,
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [ALUOP_W-1:0] ALUOp_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output logic               valid_o,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               md_start_o,
    output logic [1:0]         md_op_o,
    output logic               md_step_o,
    output logic               md_done_o,
    output logic               busy_o
`ifdef ALU_CTRL_ERR_EN
    ,
    output logic               err_o
`endif
);
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d, start_q, start_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [1:0]          op_q, op_d;
    logic [CTRL_W-1:0]   dec_code;
    logic                dec_md;
    logic [1:0]          dec_op;
`ifdef ALU_CTRL_ERR_EN
    logic                err_q, err_d, dec_ill;
`endif

    alu_ctrl_dec #(.ALUOP_W(ALUOP_W), .FUNCT_W(FUNCT_W), .CTRL_W(CTRL_W)) u_dec (
        .aluop_i  (ALUOp_i),
        .funct_i  (funct_i),
        .code_o   (dec_code),
        .is_md_o  (dec_md),
        .md_op_o  (dec_op)
`ifdef ALU_CTRL_ERR_EN
        ,
        .illegal_o(dec_ill)
`endif
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        start_d = 1'b0;
        ctrl_d  = ctrl_q;
        op_d    = op_q;
`ifdef ALU_CTRL_ERR_EN
        err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (valid_i) begin
                valid_d = 1'b1;
                ctrl_d  = dec_code;
`ifdef ALU_CTRL_ERR_EN
                err_d = dec_ill;
`endif
                if (dec_md) begin
                    state_d = S_MD_RUN;
                    start_d = 1'b1;
                    op_d    = dec_op;
                    cnt_d   = CNT_W'(MD_CYCLES);
                end
            end
            // the start cycle loads operands; stepping begins the cycle after
            S_MD_RUN: if (!start_q) begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_MD_DONE : S_MD_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            ctrl_q  <= '0;
            op_q    <= '0;
`ifdef ALU_CTRL_ERR_EN
            err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            start_q <= start_d;
            ctrl_q  <= ctrl_d;
            op_q    <= op_d;
`ifdef ALU_CTRL_ERR_EN
            err_q <= err_d;
`endif
        end
    end

    assign ready_o    = state_q == S_IDLE;
    assign valid_o    = valid_q;
    assign ALUCtrl_o  = ctrl_q;
    assign md_start_o = start_q;
    assign md_op_o    = op_q;
    assign md_step_o  = (state_q == S_MD_RUN) && !start_q;
    assign md_done_o  = state_q == S_MD_DONE;
    assign busy_o     = state_q != S_IDLE;
`ifdef ALU_CTRL_ERR_EN
    assign err_o = err_q;
`endif
endmodule
